uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single transmit write port of the top-level UART FIFO (wr_en / data_in) between NUM_REQ independent byte producers.
- Grants the port to one requester at a time, round-robin, and holds the grant for a whole message: ends on last byte, MAX_BURST bytes, or idle timeout.
- Sits between the producers and the UART write interface; applies backpressure from the FIFO full flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width; matches UART data_in
- MAX_BURST, 16, maximum bytes per grant before forced release (1..255)
- TIMEOUT, 64, idle cycles with owner valid low before grant is revoked (1..1023)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  marks final byte of requester's message; qualified by req_valid
- req_ack  out  NUM_REQ  byte accepted this cycle; producer advances on clk edge
- grant  out  NUM_REQ  one-hot current owner, all-zero when idle
- fifo_full  in  1  UART TX FIFO full
- fifo_wr_en  out  1  write strobe to UART FIFO
- fifo_wdata  out  DATA_W  byte to UART FIFO
- busy  out  1  high while in BURST

Behaviour:
- Reset (reset=0, async): state=IDLE; grant=0; rr_ptr=0; byte_cnt=0; idle_cnt=0; req_ack=0; fifo_wr_en=0; fifo_wdata=0; busy=0. Applies immediately, including mid-burst; a partially sent message is abandoned.
- States: IDLE, BURST.
- IDLE:
  - If any req_valid is set, pick the first valid index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register the winner into grant, set rr_ptr = winner+1 (wraps NUM_REQ-1 -> 0), clear byte_cnt and idle_cnt, go to BURST.
  - No acks are issued in IDLE.
  - Latency: req_valid rising at edge n -> grant at n+1 -> earliest ack in the cycle after n+1.
- BURST:
  - accept = req_valid[owner] & ~fifo_full (combinational).
  - On accept: req_ack[owner]=1, fifo_wr_en=1, fifo_wdata=req_data[owner]. These are combinational from registered grant and the inputs, so one byte can be taken per cycle.
  - On accept: byte_cnt+1 and idle_cnt=0.
  - Release to IDLE (grant=0 next cycle) when the accepted byte has req_last=1, or byte_cnt reaches MAX_BURST on this accept.
  - Owner req_valid low, or fifo_full high, does not count toward byte_cnt. req_valid low increments idle_cnt; fifo_full alone does not. Release when idle_cnt reaches TIMEOUT.
  - fifo_full stalls with no ack and no write; grant is held indefinitely.
- Non-owner requesters are never acked. fifo_wdata holds its last value when fifo_wr_en=0.
- After release there is always at least one IDLE cycle (one-cycle arbitration bubble).
- Simultaneous events: last=1 on the MAX_BURST-th byte gives a single release. Timeout and accept cannot coincide, because accept clears idle_cnt.
- Widths: byte_cnt is 8 bits; idle_cnt is 10 bits. Both saturate and never wrap.

Optional Feature:
- Macro: UART_ARB_PRIO_EN.
- Defined: at each IDLE arbitration, requester 0 wins whenever its req_valid is set, regardless of rr_ptr. rr_ptr still updates only when a requester other than 0 wins. Other requesters rotate as normal.
- Undefined: pure round-robin as described; requester 0 has no special status.

Test Plan:
- Single requester: req 1 sends 0xE7, 0x86, 0xF6 with last on 0xF6, fifo_full=0 -> grant=0b0010 one cycle after valid; three consecutive fifo_wr_en pulses carrying those bytes; grant=0 next cycle; rr_ptr=2.
- Round-robin: reqs 0, 2, 3 all valid with 1-byte messages (last=1) -> grants issued in order 0, 2, 3, each separated by one IDLE cycle. With UART_ARB_PRIO_EN and req 0 re-requesting, order becomes 0, 0, 2 ...
- MAX_BURST=4, req 0 streams 6 bytes 0x00..0x05 with last only on 0x05 -> release after 0x03; a competing req 1 gets the next grant; req 0 resumes later with 0x04.
- Backpressure: fifo_full=1 for 10 cycles mid-message -> no ack and no write; grant held; byte stream resumes intact with no loss or duplicate once full=0.
- Timeout: TIMEOUT=8, owner drops valid after 1 byte -> grant=0 exactly 8 cycles later; a second requester is granted next.
- Reset mid-burst: assert reset low during byte 2 of 4 -> all outputs 0 asynchronously; after release, IDLE arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO write port among NUM_REQ byte producers.
// Optional UART_ARB_PRIO_EN: requester 0 wins every arbitration it takes part in.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wdata,
  output logic                      busy
);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [9:0] IDLE_LAST  = 10'(TIMEOUT - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state;
  logic [PW-1:0]       rr_ptr;
  logic [7:0]          byte_cnt;
  logic [9:0]          idle_cnt;
  logic [DATA_W-1:0]   wdata_q;

  logic [DATA_W-1:0]   own_data;
  logic                own_valid, own_last, accept;
  logic [NUM_REQ-1:0]  rot, win_oh;
  logic [PW-1:0]       rr_nxt;
  logic                upd_rr;
  int                  off, win_i;

  // Owner's byte, valid and last selected by the one-hot grant
  always_comb begin
    own_data  = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        own_data  = own_data | req_data[i*DATA_W +: DATA_W];
        own_valid = own_valid | req_valid[i];
        own_last  = own_last | req_last[i];
      end
    end
  end

  // Rotate valids so bit 0 is rr_ptr; lowest set bit is the winner offset
  always_comb begin
    rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    off = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (rot[k]) off = k;
    win_i = int'(rr_ptr) + off;
    if (win_i >= NUM_REQ) win_i = win_i - NUM_REQ;
    upd_rr = 1'b1;
`ifdef UART_ARB_PRIO_EN
    if (req_valid[0]) begin
      win_i  = 0;
      upd_rr = 1'b0;
    end
`endif
    rr_nxt = (win_i == NUM_REQ - 1) ? '0 : PW'(win_i + 1);
    for (int i = 0; i < NUM_REQ; i++) win_oh[i] = (i == win_i);
  end

  assign busy       = (state == BURST);
  assign accept     = busy & own_valid & ~fifo_full;
  assign req_ack    = accept ? grant : '0;
  assign fifo_wr_en = accept;
  assign fifo_wdata = accept ? own_data : wdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      byte_cnt <= '0;
      idle_cnt <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant    <= win_oh;
            if (upd_rr) rr_ptr <= rr_nxt;
            byte_cnt <= '0;
            idle_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            wdata_q  <= own_data;
            byte_cnt <= (byte_cnt == 8'hFF) ? byte_cnt : byte_cnt + 8'd1;
            idle_cnt <= '0;
            if (own_last || byte_cnt == BURST_LAST) begin
              grant <= '0;
              state <= IDLE;
            end
          end else if (!own_valid) begin
            // A full FIFO alone stalls without aging the grant
            idle_cnt <= (idle_cnt == 10'h3FF) ? idle_cnt : idle_cnt + 10'd1;
            if (idle_cnt == IDLE_LAST) begin
              grant <= '0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_uart_tx_arbiter;
  localparam int N = 4, W = 8, MB = 4, TO = 8;

  logic clk = 1'b0, reset = 1'b0;
  logic [N-1:0] req_valid, req_last, req_ack, grant;
  logic [N*W-1:0] req_data;
  logic fifo_full, fifo_wr_en, busy;
  logic [W-1:0] fifo_wdata;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ack(req_ack), .grant(grant), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .busy(busy));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [8:0] pbuf [N][1024];
  int ph [N], pt [N], quiet [N];
  logic [N-1:0] en;
  logic [N-1:0] ghist [0:19999];
  logic [7:0] wr_log [$], exp_q [$];
  int wr_cyc [$];

  // Model: who owns the port, bytes sent and idle cycles under this grant
  int m_own = -1, m_rr = 0, m_nb = 0, m_idle = 0;
  logic [7:0] m_wd = 8'h00;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(int r, logic [7:0] b, bit last);
    pbuf[r][pt[r] % 1024] = {last, b};
    pt[r]++;
  endtask

  task automatic push_msg(int r, logic [7:0] base, int len);
    for (int k = 0; k < len; k++) push(r, base + 8'(k), k == len - 1);
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (en[i] && ph[i] != pt[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bit v;
      v = en[i] && ph[i] != pt[i] && quiet[i] == 0;
      req_valid[i] = v;
      {req_last[i], req_data[i*W +: W]} = v ? pbuf[i][ph[i] % 1024] : 9'h0;
    end
  endtask

  function automatic bit m_accept();
    return m_own >= 0 && req_valid[m_own] && !fifo_full;
  endfunction

  task automatic sample();
    logic [N-1:0] eg;
    bit acc;
    acc = m_accept();
    eg = (m_own >= 0) ? N'(1) << m_own : '0;
    chk("grant", grant, eg);
    chk("busy", busy, m_own >= 0);
    chk("wr_en", fifo_wr_en, acc);
    chk("ack", req_ack, acc ? eg : '0);
    chk("wdata", fifo_wdata, acc ? req_data[m_own*W +: W] : m_wd);
    if (cyc < 20000) ghist[cyc] = grant;
    if (fifo_wr_en) begin
      wr_log.push_back(fifo_wdata);
      wr_cyc.push_back(cyc);
    end
  endtask

  task automatic update();
    if (m_own < 0) begin
      if (|req_valid) begin
        int w;
        bit upd;
        w = -1;
        upd = 1'b1;
`ifdef UART_ARB_PRIO_EN
        if (req_valid[0]) begin w = 0; upd = 1'b0; end
`endif
        for (int k = 0; k < N && w < 0; k++)
          if (req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
        if (upd) m_rr = (w + 1) % N;
        m_own = w; m_nb = 0; m_idle = 0;
      end
    end else if (m_accept()) begin
      m_nb++;
      m_idle = 0;
      m_wd = req_data[m_own*W +: W];
      ph[m_own]++;
      if (req_last[m_own] || m_nb == MB) m_own = -1;
    end else if (!req_valid[m_own]) begin
      m_idle++;
      if (m_idle == TO) m_own = -1;
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    sample();
    @(posedge clk);
    if (reset) update();
    cyc++;
    #1;
  endtask

  task automatic drain(string nm, int maxc);
    int n = 0;
    while ((m_own >= 0 || pending()) && n < maxc) begin cycle(); n++; end
    chk({nm, "_done"}, n < maxc, 1);
    cycle(); cycle();
  endtask

  task automatic until_writes(string nm, int cnt);
    int n = 0;
    while (wr_log.size() < cnt && n < 40) begin cycle(); n++; end
    chk({nm, "_reached"}, n < 40, 1);
  endtask

  task automatic chk_q(string nm);
    chk({nm, "_n"}, wr_log.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < wr_log.size(); k++)
      chk($sformatf("%s_%0d", nm, k), wr_log[k], exp_q[k]);
  endtask

  task automatic clr();
    wr_log.delete(); wr_cyc.delete(); exp_q.delete();
  endtask

  initial begin
    int c0, ca;
    req_valid = '0; req_data = '0; req_last = '0; fifo_full = 1'b0; en = '1;
    for (int i = 0; i < N; i++) quiet[i] = 0;

    #12;
    chk("rst_grant", grant, 0); chk("rst_busy", busy, 0);
    chk("rst_wr", fifo_wr_en, 0); chk("rst_ack", req_ack, 0); chk("rst_wdata", fifo_wdata, 0);
    @(posedge clk); #1; reset = 1'b1;

    // Round-robin of three one-byte messages
    clr(); c0 = cyc;
    push(0, 8'hA0, 1); push(2, 8'hA2, 1); push(3, 8'hA3, 1);
    drain("rr", 40);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
    chk_q("rr");
    if (wr_cyc.size() == 3) begin
      chk("rr_first", wr_cyc[0], c0 + 1);
      chk("rr_gap1", wr_cyc[1] - wr_cyc[0], 2);
      chk("rr_gap2", wr_cyc[2] - wr_cyc[1], 2);
    end

    // Single requester, three bytes back to back
    clr(); c0 = cyc;
    push(1, 8'hE7, 0); push(1, 8'h86, 0); push(1, 8'hF6, 1);
    drain("single", 40);
    exp_q.push_back(8'hE7); exp_q.push_back(8'h86); exp_q.push_back(8'hF6);
    chk_q("single");
    chk("single_g0", ghist[c0], 0);
    chk("single_g1", ghist[c0 + 1], 4'b0010);
    chk("single_g4", ghist[c0 + 4], 0);
    if (wr_cyc.size() == 3) chk("single_last_cyc", wr_cyc[2], c0 + 3);

    // rr_ptr now 2: req 3 beats req 1
    clr(); c0 = cyc;
    push(1, 8'h61, 1); push(3, 8'h63, 1);
    drain("ptr2", 40);
    chk("ptr2_grant", ghist[c0 + 1], 4'b1000);
    exp_q.push_back(8'h63); exp_q.push_back(8'h61);
    chk_q("ptr2");

    // MAX_BURST split with a competing requester
    clr();
    push_msg(0, 8'h00, 6); push(1, 8'h11, 1);
    drain("maxb", 60);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(k));
`ifdef UART_ARB_PRIO_EN
    exp_q.push_back(8'h04); exp_q.push_back(8'h05); exp_q.push_back(8'h11);
`else
    exp_q.push_back(8'h11); exp_q.push_back(8'h04); exp_q.push_back(8'h05);
`endif
    chk_q("maxb");

    // Backpressure for 10 cycles after the first byte
    clr();
    push_msg(2, 8'h20, 4);
    until_writes("bp", 1);
    fifo_full = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("bp_hold", ghist[cyc - 1], 4'b0100);
    end
    chk("bp_nowrite", wr_log.size(), 1);
    fifo_full = 1'b0;
    drain("bp", 40);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'h20 + 8'(k));
    chk_q("bp");
    if (wr_cyc.size() == 4) chk("bp_release", ghist[wr_cyc[3] + 1], 0);

    // Idle timeout, then a second requester takes over
    clr();
    push_msg(3, 8'h30, 3);
    until_writes("to", 1);
    ca = wr_cyc[0];
    en[3] = 1'b0;
    push(1, 8'h19, 1);
    for (int k = 0; k < 12; k++) cycle();
    chk("to_held", ghist[ca + 8], 4'b1000);
    chk("to_drop", ghist[ca + 9], 0);
    chk("to_next", ghist[ca + 10], 4'b0010);
    en[3] = 1'b1;
    drain("to", 60);
    exp_q.push_back(8'h30); exp_q.push_back(8'h19); exp_q.push_back(8'h31); exp_q.push_back(8'h32);
    chk_q("to");

    // Reset during byte 2 of 4
    clr();
    push_msg(0, 8'h40, 4);
    en[2] = 1'b0; push(2, 8'h52, 1);
    until_writes("rst", 1);
    drive();
    @(negedge clk);
    sample();
    cyc++;
    #2 reset = 1'b0;
    #1;
    chk("mrst_grant", grant, 0); chk("mrst_busy", busy, 0); chk("mrst_wr", fifo_wr_en, 0);
    chk("mrst_ack", req_ack, 0); chk("mrst_wdata", fifo_wdata, 0);
    m_own = -1; m_rr = 0; m_nb = 0; m_idle = 0; m_wd = 8'h00;
    @(posedge clk); #1;
    chk("mrst_hold", grant, 0);
    reset = 1'b1; en[2] = 1'b1;
    drain("mrst", 60);
    exp_q.push_back(8'h40); exp_q.push_back(8'h41); exp_q.push_back(8'h41);
    exp_q.push_back(8'h42); exp_q.push_back(8'h43); exp_q.push_back(8'h52);
    chk_q("mrst");

    // Random traffic
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (ph[i] == pt[i] && $urandom_range(0, 7) == 0) begin
          int len;
          len = $urandom_range(1, 6);
          for (int k = 0; k < len; k++) push(i, 8'($urandom), k == len - 1);
        end
        if (quiet[i] > 0) quiet[i]--;
        else if ($urandom_range(0, 39) == 0) quiet[i] = $urandom_range(1, 12);
        en[i] = $urandom_range(0, 4) != 0;
      end
      fifo_full = $urandom_range(0, 4) == 0;
      cycle();
    end
    fifo_full = 1'b0; en = '1;
    for (int i = 0; i < N; i++) quiet[i] = 0;
    drain("rand", 500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
